control_unit_top: RTL and testbench

Combinational instruction decoder for the single-cycle RV32I datapath. It maps the opcode, funct3 and funct7 fields of the current instruction to the datapath control strobes: register write, immediate format, ALU operand select, memory write, result select, branch and ALU operation. It sits between instruction memory and the register file, immediate generator, ALU and data memory.

---
 rtl/control_unit_top_pkg.sv | 39 +++
 rtl/control_unit_top_alu_decoder.sv | 35 +++
 rtl/control_unit_top.sv | 104 ++++++++++
 tb/tb_control_unit_top.sv | 130 +++++++++++++
 4 files changed

// File: rtl/control_unit_top_pkg.sv
// Shared encodings for the RV32I single-cycle control unit.
package control_unit_top_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Main-decoder to ALU-decoder operation class
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // ALU operation select
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  // Immediate format select
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

endpackage

// File: rtl/control_unit_top_alu_decoder.sv
// ALU decoder: turns ALUOp plus funct fields into the ALU operation select.
module alu_decoder
  import control_unit_top_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  alu_ctrl_t ctrl;

  // Select ALU operation; sub only for R-type funct3=000 with funct7[5] set
  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl = ALU_SLT;
          3'b110:  ctrl = ALU_OR;
          3'b111:  ctrl = ALU_AND;
          default: ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign alu_control = ctrl;

endmodule

// File: rtl/control_unit_top.sv
// Combinational RV32I control unit: main decoder, ALU decoder and
// asynchronous active-low output gating. clk is carried for port uniformity.
module control_unit_top
  import control_unit_top_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       ResultSrc,
  output logic       Branch,
  output logic [2:0] ALUControl
);

  logic       reg_write;
  imm_src_t   imm_src;
  logic       alu_src;
  logic       mem_write;
  logic       result_src;
  logic       branch;
  alu_op_t    alu_op;
  logic [2:0] alu_control;

  // clk and the unused funct7 bits feed no logic
  logic unused_inputs;
  assign unused_inputs = ^{clk, funct7[6], funct7[4:0]};

  // Main decoder: opcode to datapath strobes and ALUOp; unsupported ops are NOPs
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    case (Op)
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 1'b1;
      end
      OP_STORE: begin
        imm_src   = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = ALUOP_SUB;
      end
      OP_ITYPE: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        reg_write = 1'b0;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (Op[5]),
    .funct7b5    (funct7[5]),
    .alu_control (alu_control)
  );

  // Reset gating is combinational so outputs clear and recover without a clock
  always_comb begin
    RegWrite   = 1'b0;
    ImmSrc     = '0;
    ALUSrc     = 1'b0;
    MemWrite   = 1'b0;
    ResultSrc  = 1'b0;
    Branch     = 1'b0;
    ALUControl = '0;
    if (rst) begin
      RegWrite   = reg_write;
      ImmSrc     = imm_src;
      ALUSrc     = alu_src;
      MemWrite   = mem_write;
      ResultSrc  = result_src;
      Branch     = branch;
      ALUControl = alu_control;
    end
  end

endmodule

// File: tb/tb_control_unit_top.sv
// Directed self-checking bench for control_unit_top.
// Output vector layout: {RegWrite, ImmSrc[1:0], ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}
module tb_control_unit_top;

  logic       clk;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic       ALUSrc;
  logic       MemWrite;
  logic       ResultSrc;
  logic       Branch;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  control_unit_top dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .funct3     (funct3),
    .funct7     (funct7),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .MemWrite   (MemWrite),
    .ResultSrc  (ResultSrc),
    .Branch     (Branch),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl};
  endfunction

  task automatic check(input string tag, input logic [9:0] expected);
    logic [9:0] observed;
    observed = outs();
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Drive an instruction just after a falling clk edge so sampling is far from posedge
  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    Op     = op;
    funct3 = f3;
    funct7 = f7;
    #2;
  endtask

  initial begin
    rst    = 1'b0;
    Op     = 7'b0000011;
    funct3 = 3'b010;
    funct7 = 7'b0000000;
    #1;
    check("reset_load", 10'b0_00_0_0_0_0_000);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("load",       10'b1_00_1_0_1_0_000);

    apply(7'b0100011, 3'b010, 7'b0000000);
    check("store",      10'b0_01_1_1_0_0_000);

    apply(7'b0110011, 3'b010, 7'b0000000);
    check("r_slt",      10'b1_00_0_0_0_0_101);
    apply(7'b0110011, 3'b000, 7'b0100000);
    check("r_sub",      10'b1_00_0_0_0_0_001);
    apply(7'b0110011, 3'b000, 7'b0000000);
    check("r_add",      10'b1_00_0_0_0_0_000);
    apply(7'b0110011, 3'b110, 7'b0000000);
    check("r_or",       10'b1_00_0_0_0_0_011);
    apply(7'b0110011, 3'b111, 7'b0000000);
    check("r_and",      10'b1_00_0_0_0_0_010);
    apply(7'b0110011, 3'b001, 7'b0000000);
    check("r_other_f3", 10'b1_00_0_0_0_0_000);

    apply(7'b1100011, 3'b010, 7'b0000000);
    check("branch",     10'b0_10_0_0_0_1_001);

    apply(7'b0010011, 3'b000, 7'b0100000);
    check("addi_f7",    10'b1_00_1_0_0_0_000);
    apply(7'b0010011, 3'b010, 7'b0000000);
    check("slti",       10'b1_00_1_0_0_0_101);
    apply(7'b0010011, 3'b111, 7'b0000000);
    check("andi",       10'b1_00_1_0_0_0_010);

    apply(7'b1100111, 3'b000, 7'b0100000);
    check("nop_jalr",   10'b0_00_0_0_0_0_000);
    apply(7'b1101111, 3'b010, 7'b0100000);
    check("nop_jal",    10'b0_00_0_0_0_0_000);
    apply(7'b0110111, 3'b110, 7'b0100000);
    check("nop_lui",    10'b0_00_0_0_0_0_000);
    apply(7'b0010111, 3'b111, 7'b0100000);
    check("nop_auipc",  10'b0_00_0_0_0_0_000);
    apply(7'b1111111, 3'b010, 7'b1111111);
    check("nop_ones",   10'b0_00_0_0_0_0_000);

    // Asynchronous reset mid-stream, away from any clock edge
    apply(7'b0110011, 3'b110, 7'b0000000);
    check("pre_async",  10'b1_00_0_0_0_0_011);
    rst = 1'b0;
    #1;
    check("async_rst",  10'b0_00_0_0_0_0_000);
    funct3 = 3'b010;
    #1;
    check("rst_hold",   10'b0_00_0_0_0_0_000);
    rst = 1'b1;
    #1;
    check("rst_release", 10'b1_00_0_0_0_0_101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
